mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Parametrised MEM pipeline stage for the XPU core; successor to the pass-through MEM stage.
//  Forwards ALU and CSR results to MEM/WB and drives the ID-stage forwarding (mem_back_*) path.
//  Executes loads and stores over a req/ack data-memory bus through a 3-state FSM.
//  Stalls the upstream pipeline while an access is outstanding.
// PARAMETERS
//  XLEN        32   data/address width (32 or 64)
//  REG_AW      5    GPR address width
//  CSR_AW      12   CSR address width
//  TIMEOUT     255  max BUSY cycles without ack before bus error (8-bit counter, 1..255)
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        synchronous reset, active-high
//  valid_i          in   1        EX/MEM holds a valid instruction
//  flush_i          in   1        kill current instruction (trap/branch)
//  rd_addr_i        in   REG_AW   destination GPR
//  wreg_i           in   1        writes GPR
//  wdata_i          in   XLEN     ALU result; effective address for load/store
//  csr_waddr_i      in   CSR_AW   CSR address;  csr_wreg_i in 1;  csr_wdata_i in XLEN
//  is_load_i        in   1        load;  is_store_i in 1 store (never both)
//  funct3_i         in   3        000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU
//  store_data_i     in   XLEN     rs2 value for stores
//  dmem_req_o       out  1        bus request (registered)
//  dmem_we_o        out  1        write enable;  dmem_addr_o out XLEN (aligned to XLEN/8)
//  dmem_wdata_o     out  XLEN     lane-replicated store data;  dmem_be_o out XLEN/8 byte enables
//  dmem_ack_i       in   1        one-cycle ack;  dmem_rdata_i in XLEN read data
//  stall_req_o      out  1        hold EX/MEM and everything upstream
//  rd_addr_o/wreg_o/wdata_o, csr_waddr_o/csr_wreg_o/csr_wdata_o  out  to MEM/WB
//  mem_back_{rd_addr,wreg,wdata,csr_waddr,csr_wreg,csr_wdata}_o  out  forwarding copy, same values
//  bus_err_o        out  1        one-cycle pulse: access timed out
// BEHAVIOUR
//  Reset: state=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, counter=0, load reg=0, bus_err_o=0.
//   All other outputs derive from inputs and reset state; wreg_o=csr_wreg_o=0 while rst is high.
//  Non-memory op (valid_i, no load/store): zero-latency combinational pass-through; stall_req_o=0.
//  !valid_i or flush_i: wreg_o=csr_wreg_o=0 (gating applies in IDLE only).
//  FSM IDLE: valid memory op and !flush_i -> stall_req_o=1 (comb); next state BUSY; req=1.
//   dmem_addr/we/be/wdata registered at this edge.
//  FSM BUSY: req held, stall_req_o=1, wreg_o=0; counter increments each cycle.
//   dmem_ack_i=1 -> DONE, req=0, sign/zero-extended load lane captured.
//   counter==TIMEOUT without ack -> DONE with error; req=0; bus_err_o pulses; writeback suppressed.
//  FSM DONE: stall_req_o=0; load: wreg_o=wreg_i, wdata_o=captured data; store: wreg_o=0; -> IDLE.
//  Minimum latency: ack in 1st BUSY cycle -> 3 cycles (IDLE, BUSY, DONE).
//  Extraction uses addr[log2(XLEN/8)-1:0] lane; B/H/W sign-extend, BU/HU/WU zero-extend.
//  Byte enables: B=1 bit, H=2 bits, W=4 bits shifted by lane offset; D=all ones.
//  flush_i in BUSY: the bus transaction is not abandoned; wait for ack or timeout,
//   then DONE with writeback suppressed.
//  Ack while IDLE or DONE: ignored.  Reset mid-BUSY: state->IDLE, req=0 at that edge.
//  CSR fields pass through unchanged in all states; csr_wreg_o gated like wreg_o.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: misaligned access (H odd, W addr[1:0]!=0, D addr[2:0]!=0) issues no request.
//   -> DONE directly, misalign_o (out 1) pulses, writeback suppressed.
//  Undefined: misalign_o absent; low address bits are used as the lane offset.
//   Accesses that cross a word are truncated to the lanes that fit.
// TESTING
//  LW addr 0x100, ack after 1 BUSY cycle, rdata 0xDEADBEEF -> wdata_o=0xDEADBEEF in DONE; stall high 2 cycles.
//  LB addr 0x103, rdata 0x80112233 -> wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x102, data 0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD, we=1, wreg_o=0 in DONE.
//  No ack, TIMEOUT=4 -> req drops after 4 BUSY cycles, bus_err_o pulses, wreg_o=0.
//  ADD result 0x5, rd=3 -> wreg_o=1, mem_back_wdata_o=0x5 same cycle; flush in BUSY -> no writeback.
//  rst asserted in BUSY -> next cycle req=0, stall=0, state IDLE.  With MEM_MISALIGN_TRAP_EN: LW 0x101 -> misalign_o, no req.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage of the XPU core.
// Forwards ALU/CSR results to MEM/WB and to the ID-stage forwarding path.
// Runs loads and stores over a req/ack data bus with an IDLE/BUSY/DONE FSM.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses trap
// instead of being truncated to the lanes that fit; adds misalign_o).
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int CSR_AW  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [CSR_AW-1:0] csr_waddr_i,
  input  logic              csr_wreg_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   store_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_req_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic              csr_wreg_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic [REG_AW-1:0] mem_back_rd_addr_o,
  output logic              mem_back_wreg_o,
  output logic [XLEN-1:0]   mem_back_wdata_o,
  output logic [CSR_AW-1:0] mem_back_csr_waddr_o,
  output logic              mem_back_csr_wreg_o,
  output logic [XLEN-1:0]   mem_back_csr_wdata_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              bus_err_o
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Byte enables: size mask shifted to the lane; bits past the word fall off.
  function automatic logic [NB-1:0] calc_be(input logic [2:0] f3, input logic [LW-1:0] lane);
    logic [NB-1:0] base;
    case (f3[1:0])
      2'b00:   base = NB'(1'b1);
      2'b01:   base = NB'(2'b11);
      2'b10:   base = NB'(4'b1111);
      default: base = {NB{1'b1}};
    endcase
    calc_be = (f3[1:0] == 2'b11) ? base : (base << lane);
  endfunction

  // Store data replicated across every lane of its size.
  function automatic logic [XLEN-1:0] rep_store(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   rep_store = {NB{d[7:0]}};
      2'b01:   rep_store = {(NB/2){d[15:0]}};
      2'b10:   rep_store = {(NB/4){d[31:0]}};
      default: rep_store = d;
    endcase
  endfunction

  // Load lane extraction with sign or zero extension.
  function automatic logic [XLEN-1:0] ext_load(input logic [2:0] f3, input logic [LW-1:0] lane,
                                               input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh;
    sh = rd >> {lane, 3'b000};
    case (f3)
      3'b000:  ext_load = XLEN'($signed(sh[7:0]));
      3'b001:  ext_load = XLEN'($signed(sh[15:0]));
      3'b010:  ext_load = XLEN'($signed(sh[31:0]));
      3'b100:  ext_load = XLEN'(sh[7:0]);
      3'b101:  ext_load = XLEN'(sh[15:0]);
      3'b110:  ext_load = XLEN'(sh[31:0]);
      default: ext_load = sh;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Natural-alignment check for H/W/D accesses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [LW-1:0] lane);
    case (f3[1:0])
      2'b01:   is_misaligned = lane[0];
      2'b10:   is_misaligned = (lane[1:0] != 2'b00);
      2'b11:   is_misaligned = (lane != {LW{1'b0}});
      default: is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdat_q, wdat_d;
  logic [NB-1:0]     be_q, be_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   load_q, load_d;
  logic              bus_err_q, bus_err_d;
  logic              kill_q, kill_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [LW-1:0]     lane_q, lane_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
`endif

  logic              mem_op_s, start_s, trap_s;
  logic [LW-1:0]     lane_s;
  logic [7:0]        cnt_inc_s;
  logic              stall_s, wreg_s, csr_wreg_s;
  logic [XLEN-1:0]   wdata_s;

  assign mem_op_s  = is_load_i | is_store_i;
  assign start_s   = valid_i & mem_op_s & ~flush_i;
  assign lane_s    = wdata_i[LW-1:0];
  assign cnt_inc_s = cnt_q + 8'd1;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s     = is_misaligned(funct3_i, lane_s);
  assign misalign_d = (state_q == S_IDLE) & start_s & trap_s;
  assign misalign_o = misalign_q;
`else
  assign trap_s = 1'b0;
`endif

  // FSM next state and bus-side register updates
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    bus_err_d = 1'b0;
    kill_d    = kill_q;
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    lane_d    = lane_q;
    case (state_q)
      S_IDLE: begin
        if (start_s && trap_s) begin
          state_d   = S_DONE;
          kill_d    = 1'b1;
          is_load_d = is_load_i;
          funct3_d  = funct3_i;
          lane_d    = lane_s;
        end else if (start_s) begin
          state_d   = S_BUSY;
          req_d     = 1'b1;
          we_d      = is_store_i;
          addr_d    = {wdata_i[XLEN-1:LW], {LW{1'b0}}};
          wdat_d    = is_store_i ? rep_store(funct3_i, store_data_i) : {XLEN{1'b0}};
          be_d      = calc_be(funct3_i, lane_s);
          cnt_d     = 8'd0;
          kill_d    = 1'b0;
          is_load_d = is_load_i;
          funct3_d  = funct3_i;
          lane_d    = lane_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d  = cnt_inc_s;
        // a flush cannot abandon the bus cycle; it only kills the writeback
        kill_d = kill_q | flush_i;
        if (dmem_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = {NB{1'b0}};
          load_d  = ext_load(funct3_q, lane_q, dmem_rdata_i);
        end else if (cnt_inc_s == 8'(TIMEOUT)) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          be_d      = {NB{1'b0}};
          kill_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        be_d    = {NB{1'b0}};
      end
    endcase
  end

  // Writeback gating, load data selection and upstream stall
  always_comb begin
    stall_s    = 1'b0;
    wreg_s     = 1'b0;
    csr_wreg_s = 1'b0;
    wdata_s    = wdata_i;
    if (rst) begin
      stall_s    = 1'b0;
      wreg_s     = 1'b0;
      csr_wreg_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i && !flush_i && mem_op_s) begin
            stall_s = 1'b1;
          end else if (valid_i && !flush_i) begin
            wreg_s     = wreg_i;
            csr_wreg_s = csr_wreg_i;
          end else begin
            wreg_s     = 1'b0;
            csr_wreg_s = 1'b0;
          end
        end
        S_BUSY: begin
          stall_s = 1'b1;
        end
        S_DONE: begin
          if (is_load_q) begin
            wdata_s    = load_q;
            wreg_s     = wreg_i & ~kill_q;
            csr_wreg_s = csr_wreg_i & ~kill_q;
          end else begin
            wreg_s     = 1'b0;
            csr_wreg_s = 1'b0;
          end
        end
        default: begin
          stall_s = 1'b0;
        end
      endcase
    end
  end

  // State and bus register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {XLEN{1'b0}};
      wdat_q    <= {XLEN{1'b0}};
      be_q      <= {NB{1'b0}};
      cnt_q     <= 8'd0;
      load_q    <= {XLEN{1'b0}};
      bus_err_q <= 1'b0;
      kill_q    <= 1'b0;
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= {LW{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      bus_err_q <= bus_err_d;
      kill_q    <= kill_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      lane_q    <= lane_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdat_q;
  assign dmem_be_o    = be_q;
  assign bus_err_o    = bus_err_q;
  assign stall_req_o  = stall_s;

  assign rd_addr_o   = rd_addr_i;
  assign wreg_o      = wreg_s;
  assign wdata_o     = wdata_s;
  assign csr_waddr_o = csr_waddr_i;
  assign csr_wreg_o  = csr_wreg_s;
  assign csr_wdata_o = csr_wdata_i;

  assign mem_back_rd_addr_o   = rd_addr_i;
  assign mem_back_wreg_o      = wreg_s;
  assign mem_back_wdata_o     = wdata_s;
  assign mem_back_csr_waddr_o = csr_waddr_i;
  assign mem_back_csr_wreg_o  = csr_wreg_s;
  assign mem_back_csr_wdata_o = csr_wdata_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (XLEN=32, TIMEOUT=4).
module tb_mem_access_stage;
  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int CSR_AW  = 12;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i, flush_i, wreg_i, csr_wreg_i, is_load_i, is_store_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic [XLEN-1:0]   wdata_i, csr_wdata_i, store_data_i, dmem_rdata_i;
  logic [CSR_AW-1:0] csr_waddr_i;
  logic [2:0]        funct3_i;
  logic              dmem_ack_i;
  logic              dmem_req_o, dmem_we_o, stall_req_o, bus_err_o;
  logic [XLEN-1:0]   dmem_addr_o, dmem_wdata_o;
  logic [3:0]        dmem_be_o;
  logic [REG_AW-1:0] rd_addr_o, mem_back_rd_addr_o;
  logic              wreg_o, csr_wreg_o, mem_back_wreg_o, mem_back_csr_wreg_o;
  logic [XLEN-1:0]   wdata_o, csr_wdata_o, mem_back_wdata_o, mem_back_csr_wdata_o;
  logic [CSR_AW-1:0] csr_waddr_o, mem_back_csr_waddr_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CSR_AW(CSR_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
    .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .csr_waddr_i(csr_waddr_i), .csr_wreg_i(csr_wreg_i), .csr_wdata_i(csr_wdata_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_req_o(stall_req_o),
    .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .csr_waddr_o(csr_waddr_o), .csr_wreg_o(csr_wreg_o), .csr_wdata_o(csr_wdata_o),
    .mem_back_rd_addr_o(mem_back_rd_addr_o), .mem_back_wreg_o(mem_back_wreg_o),
    .mem_back_wdata_o(mem_back_wdata_o), .mem_back_csr_waddr_o(mem_back_csr_waddr_o),
    .mem_back_csr_wreg_o(mem_back_csr_wreg_o), .mem_back_csr_wdata_o(mem_back_csr_wdata_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: access size in bytes from funct3
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << m_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % m_size(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] v;
    logic [63:0] mask;
    int sz;
    sz   = m_size(f3);
    v    = {32'd0, rd} >> (8 * (a % 4));
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic go_idle();
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; flush_i = 1'b0;
    wreg_i = 1'b0; csr_wreg_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  // One load/store; ack_at = BUSY cycle carrying the ack, 0 = never (timeout)
  task automatic mem_txn(input string tag, input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rdv, input int ack_at,
                         input logic fl, input logic wr);
    int nbusy;
    logic [31:0] exp_load;
    logic exp_wb;
    nbusy    = (ack_at == 0) ? TIMEOUT : ack_at;
    exp_load = m_load(f3, addr, rdv);
    exp_wb   = ld && wr && !fl && (ack_at != 0);
    valid_i = 1'b1; is_load_i = ld; is_store_i = !ld; funct3_i = f3; wdata_i = addr;
    store_data_i = sd; rd_addr_i = REG_AW'($urandom); wreg_i = wr; csr_wreg_i = 1'b0;
    csr_wdata_i = $urandom; csr_waddr_i = CSR_AW'($urandom); flush_i = 1'b0; dmem_ack_i = 1'b0;
    #1;
    chk({tag, ".idle_stall"}, stall_req_o, 1'b1);
    chk({tag, ".idle_req"}, dmem_req_o, 1'b0);
    chk({tag, ".idle_wreg"}, wreg_o, 1'b0);
    tick();
    chk({tag, ".addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
    chk({tag, ".we"}, dmem_we_o, !ld);
    chk({tag, ".be"}, dmem_be_o, m_be(f3, addr));
    if (!ld) chk({tag, ".wdata"}, dmem_wdata_o, m_wdata(f3, sd));
    for (int c = 1; c <= nbusy; c++) begin
      chk({tag, ".busy_req"}, dmem_req_o, 1'b1);
      chk({tag, ".busy_stall"}, stall_req_o, 1'b1);
      chk({tag, ".busy_wreg"}, wreg_o, 1'b0);
      if (c == ack_at) begin
        dmem_ack_i = 1'b1; dmem_rdata_i = rdv;
      end
      flush_i = fl && (c == 1);
      tick();
      dmem_ack_i = 1'b0; flush_i = 1'b0; dmem_rdata_i = $urandom;
    end
    #1;
    chk({tag, ".done_req"}, dmem_req_o, 1'b0);
    chk({tag, ".done_stall"}, stall_req_o, 1'b0);
    chk({tag, ".done_buserr"}, bus_err_o, ack_at == 0);
    chk({tag, ".done_wreg"}, wreg_o, exp_wb);
    chk({tag, ".done_fwd_wreg"}, mem_back_wreg_o, exp_wb);
    chk({tag, ".done_csr_wdata"}, csr_wdata_o, csr_wdata_i);
    if (exp_wb) begin
      chk({tag, ".done_wdata"}, wdata_o, exp_load);
      chk({tag, ".done_fwd_wdata"}, mem_back_wdata_o, exp_load);
      chk({tag, ".done_rd"}, rd_addr_o, rd_addr_i);
    end
    go_idle();
    tick();
    chk({tag, ".post_buserr"}, bus_err_o, 1'b0);
    chk({tag, ".post_req"}, dmem_req_o, 1'b0);
  endtask

  // Non-memory op: zero-latency pass-through, gated by flush
  task automatic alu_op(input string tag, input logic [4:0] rd, input logic wr,
                        input logic [31:0] res, input logic fl);
    logic cw;
    cw = 1'(($urandom));
    valid_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0; flush_i = fl;
    rd_addr_i = rd; wreg_i = wr; wdata_i = res;
    csr_wreg_i = cw; csr_waddr_i = CSR_AW'($urandom); csr_wdata_i = $urandom;
    #1;
    chk({tag, ".stall"}, stall_req_o, 1'b0);
    chk({tag, ".wreg"}, wreg_o, wr && !fl);
    chk({tag, ".fwd_wreg"}, mem_back_wreg_o, wr && !fl);
    chk({tag, ".wdata"}, wdata_o, res);
    chk({tag, ".fwd_wdata"}, mem_back_wdata_o, res);
    chk({tag, ".rd"}, mem_back_rd_addr_o, rd);
    chk({tag, ".csr_wreg"}, csr_wreg_o, cw && !fl);
    chk({tag, ".csr_waddr"}, mem_back_csr_waddr_o, csr_waddr_i);
    tick();
    go_idle();
  endtask

  initial begin
    logic [2:0] f3tab [6];
    logic [2:0] f3;
    logic [31:0] a;
    logic ld;
    f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b010;
    f3tab[3] = 3'b100; f3tab[4] = 3'b101; f3tab[5] = 3'b110;
    rst = 1'b1;
    go_idle();
    rd_addr_i = 5'd0; wdata_i = 32'd0; csr_waddr_i = 12'd0; csr_wdata_i = 32'd0;
    funct3_i = 3'b010; store_data_i = 32'd0; dmem_rdata_i = 32'd0;
    // reset: registered outputs cleared, writeback gated even with a valid op
    valid_i = 1'b1; wreg_i = 1'b1; csr_wreg_i = 1'b1;
    tick();
    chk("rst.req", dmem_req_o, 1'b0);
    chk("rst.we", dmem_we_o, 1'b0);
    chk("rst.be", dmem_be_o, 4'b0000);
    chk("rst.buserr", bus_err_o, 1'b0);
    chk("rst.wreg", wreg_o, 1'b0);
    chk("rst.csr_wreg", csr_wreg_o, 1'b0);
    is_load_i = 1'b1;
    #1;
    chk("rst.stall", stall_req_o, 1'b0);
    tick();
    rst = 1'b0;
    go_idle();
    tick();

    alu_op("add", 5'd3, 1'b1, 32'h0000_0005, 1'b0);
    alu_op("add_flush", 5'd3, 1'b1, 32'h0000_0005, 1'b1);
    mem_txn("lw", 1'b1, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 1'b1);
    mem_txn("lb", 1'b1, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 1, 1'b0, 1'b1);
    mem_txn("lbu", 1'b1, 3'b100, 32'h0000_0103, 32'd0, 32'h8011_2233, 2, 1'b0, 1'b1);
    mem_txn("sh", 1'b0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'd0, 1, 1'b0, 1'b1);
    mem_txn("timeout", 1'b1, 3'b010, 32'h0000_0200, 32'd0, 32'h1234_5678, 0, 1'b0, 1'b1);
    mem_txn("flush_busy", 1'b1, 3'b010, 32'h0000_0300, 32'd0, 32'h1111_2222, 3, 1'b1, 1'b1);
    mem_txn("ack_at_limit", 1'b1, 3'b001, 32'h0000_0402, 32'd0, 32'h9ABC_0000, TIMEOUT, 1'b0, 1'b1);

    // ack while IDLE is ignored
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("idle_ack.req", dmem_req_o, 1'b0);
    chk("idle_ack.stall", stall_req_o, 1'b0);

    // reset during BUSY
    valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; wdata_i = 32'h0000_0500; wreg_i = 1'b1;
    tick();
    chk("rst_busy.req_before", dmem_req_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_busy.req", dmem_req_o, 1'b0);
    chk("rst_busy.stall", stall_req_o, 1'b0);
    rst = 1'b0;
    go_idle();
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; wdata_i = 32'h0000_0101; wreg_i = 1'b1;
    #1;
    chk("misalign.stall", stall_req_o, 1'b1);
    tick();
    chk("misalign.req", dmem_req_o, 1'b0);
    chk("misalign.pulse", misalign_o, 1'b1);
    chk("misalign.wreg", wreg_o, 1'b0);
    go_idle();
    tick();
    chk("misalign.pulse_end", misalign_o, 1'b0);
`endif

    // randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom);
      f3 = ld ? f3tab[$urandom_range(0, 5)] : f3tab[$urandom_range(0, 2)];
      a  = $urandom & 32'h0000_0FFF;
`ifdef MEM_MISALIGN_TRAP_EN
      a = a & ~(32'(m_size(f3)) - 32'd1);
`endif
      mem_txn("rand", ld, f3, a, $urandom, $urandom, $urandom_range(0, TIMEOUT),
              ($urandom_range(0, 7) == 0), 1'($urandom));
      if ((n % 5) == 0) alu_op("rand_alu", 5'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
